// File: rtl/serial_parallel_pkg.sv
// Shared definitions for the serial link: COM alignment symbol, byte width, aligner states.
package serial_parallel_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COM = 8'hBC;

  typedef enum logic [1:0] {
    SEEK,
    ALIGN,
    LOCKED
  } state_t;

endpackage

// File: rtl/serial_parallel_aligner.sv
// Byte aligner/deserializer for the MSB-first clk_32f stream: hunts COM, locks, emits bytes.
// Optional macro SP_REALIGN_EN: a misplaced COM while locked drops lock and re-anchors the boundary.
module serial_parallel_aligner
  import serial_parallel_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COM_SYMBOL = COM,
  parameter int unsigned       COM_LOCK   = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              active
);

  localparam logic [3:0] LOCK_N = 4'(COM_LOCK);

  state_t            state_reg;
  logic [BYTE_W-2:0] sr_reg;
  logic [2:0]        bit_cnt_reg;
  logic [3:0]        com_cnt_reg;

  logic [BYTE_W-1:0] window;
  logic              is_com;
  logic              boundary;

  // The byte ending on the current bit, so a match can act in the same cycle it arrives.
  assign window   = {sr_reg, data_in};
  assign is_com   = (window == COM_SYMBOL);
  assign boundary = (bit_cnt_reg == 3'd7);

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_reg   <= SEEK;
      sr_reg      <= '0;
      bit_cnt_reg <= '0;
      com_cnt_reg <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      active      <= 1'b0;
    end else begin
      sr_reg      <= window[BYTE_W-2:0];
      bit_cnt_reg <= bit_cnt_reg + 3'd1;
      valid_out   <= 1'b0;

      case (state_reg)
        SEEK: begin
          if (is_com) begin
            bit_cnt_reg <= '0;
            com_cnt_reg <= 4'd1;
            if (LOCK_N == 4'd1) begin
              state_reg <= LOCKED;
              active    <= 1'b1;
            end else begin
              state_reg <= ALIGN;
            end
          end
        end

        ALIGN: begin
          // A miss returns to SEEK without re-hunting this window.
          if (boundary) begin
            if (is_com) begin
              if (com_cnt_reg + 4'd1 >= LOCK_N) begin
                com_cnt_reg <= LOCK_N;
                state_reg   <= LOCKED;
                active      <= 1'b1;
              end else begin
                com_cnt_reg <= com_cnt_reg + 4'd1;
              end
            end else begin
              com_cnt_reg <= '0;
              state_reg   <= SEEK;
            end
          end
        end

        LOCKED: begin
          if (boundary) begin
            data_out  <= window;
            valid_out <= !is_com;
          end
`ifdef SP_REALIGN_EN
          else if (is_com) begin
            active      <= 1'b0;
            state_reg   <= ALIGN;
            com_cnt_reg <= 4'd1;
            bit_cnt_reg <= '0;
          end
`endif
        end

        default: begin
          state_reg <= SEEK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parallel_aligner.sv
// Directed bench for serial_parallel_aligner; honours SP_REALIGN_EN for the misplaced-COM case.
module tb_serial_parallel_aligner;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int n_cmp  = 0;
  int n_err  = 0;
  int vcount = 0;

`ifdef SP_REALIGN_EN
  localparam bit REALIGN = 1'b1;
`else
  localparam bit REALIGN = 1'b0;
`endif

  serial_parallel_aligner dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  // Shifts one byte MSB first and counts valid strobes seen across its 8 cycles.
  task automatic send_byte(input logic [7:0] b);
    vcount = 0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (valid_out === 1'b1) vcount++;
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    data_in = 1'b0;
    repeat (2) @(posedge clk_32f);
    #1;
    reset = 1'b0;
  endtask

  task automatic lock4();
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_data", data_out, 8'h00);
    chk("rst_valid", {7'd0, valid_out}, 8'd0);
    chk("rst_active", {7'd0, active}, 8'd0);

    // 1: lock and deserialize
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
    chk("t1_active_3bc", {7'd0, active}, 8'd0);
    send_byte(8'hBC);
    chk("t1_active_4bc", {7'd0, active}, 8'd1);
    send_byte(8'hBC);
    chk("t1_bc5_strobes", 8'(vcount), 8'd0);
    chk("t1_bc5_data", data_out, 8'hBC);
    send_byte(8'hAA);
    chk("t1_aa_valid", {7'd0, valid_out}, 8'd1);
    chk("t1_aa_data", data_out, 8'hAA);
    chk("t1_aa_strobes", 8'(vcount), 8'd1);
    send_byte(8'hBB);
    chk("t1_bb_data", data_out, 8'hBB);
    chk("t1_bb_strobes", 8'(vcount), 8'd1);
    send_byte(8'hCC);
    chk("t1_cc_data", data_out, 8'hCC);
    chk("t1_cc_strobes", 8'(vcount), 8'd1);
    send_byte(8'hDD);
    chk("t1_dd_valid", {7'd0, valid_out}, 8'd1);
    chk("t1_dd_data", data_out, 8'hDD);
    chk("t1_dd_strobes", 8'(vcount), 8'd1);
    send_bit(1'b0);
    chk("t1_valid_drop", {7'd0, valid_out}, 8'd0);

    // 2: 3-bit offset before alignment
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    lock4();
    chk("t2_active", {7'd0, active}, 8'd1);
    send_byte(8'hFF);
    chk("t2_ff_valid", {7'd0, valid_out}, 8'd1);
    chk("t2_ff_data", data_out, 8'hFF);
    chk("t2_ff_strobes", 8'(vcount), 8'd1);

    // 3: broken alignment
    do_reset();
    send_byte(8'hBC); send_byte(8'hBC);
    chk("t3_active_2bc", {7'd0, active}, 8'd0);
    send_byte(8'hEA);
    chk("t3_active_ea", {7'd0, active}, 8'd0);
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
    chk("t3_active_3bc", {7'd0, active}, 8'd0);
    send_byte(8'hBC);
    chk("t3_active_4bc", {7'd0, active}, 8'd1);
    send_byte(8'hAA);
    chk("t3_aa_valid", {7'd0, valid_out}, 8'd1);
    chk("t3_aa_data", data_out, 8'hAA);

    // 4: idle interleave
    send_byte(8'hFF);
    chk("t4_ff_data", data_out, 8'hFF);
    chk("t4_ff_strobes", 8'(vcount), 8'd1);
    send_byte(8'hBC);
    chk("t4_bc_valid", {7'd0, valid_out}, 8'd0);
    chk("t4_bc_data", data_out, 8'hBC);
    chk("t4_bc_strobes", 8'(vcount), 8'd0);
    send_byte(8'hAA);
    chk("t4_aa_data", data_out, 8'hAA);
    chk("t4_aa_strobes", 8'(vcount), 8'd1);

    // 5: reset mid-stream during CC
    do_reset();
    lock4();
    send_byte(8'hAA); send_byte(8'hBB);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    reset = 1'b1;
    send_bit(1'b1);
    reset = 1'b0;
    chk("t5_rst_active", {7'd0, active}, 8'd0);
    chk("t5_rst_valid", {7'd0, valid_out}, 8'd0);
    chk("t5_rst_data", data_out, 8'h00);
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
    chk("t5_relock_3bc", {7'd0, active}, 8'd0);
    send_byte(8'hBC);
    chk("t5_relock_4bc", {7'd0, active}, 8'd1);
    send_byte(8'hAA);
    chk("t5_aa_data", data_out, 8'hAA);
    chk("t5_aa_strobes", 8'(vcount), 8'd1);

    // 6: COM shifted by 2 bits while locked; old boundary sees 00101111 = 2F first
    send_bit(1'b0); send_bit(1'b0);
    send_byte(8'hBC);
    chk("t6_shift_strobes", 8'(vcount), 8'd1);
    chk("t6_shift_data", data_out, 8'h2F);
    chk("t6_active_after_misplaced", {7'd0, active}, REALIGN ? 8'd0 : 8'd1);
    send_byte(8'hBC); send_byte(8'hBC);
    chk("t6_active_2more", {7'd0, active}, REALIGN ? 8'd0 : 8'd1);
    chk("t6_2more_data", data_out, 8'h2F);
    send_byte(8'hBC);
    chk("t6_active_3more", {7'd0, active}, 8'd1);
    send_byte(8'hAA);
    chk("t6_aa_strobes", 8'(vcount), 8'd1);
    chk("t6_aa_data", data_out, REALIGN ? 8'hAA : 8'h2A);
    chk("t6_aa_valid", {7'd0, valid_out}, REALIGN ? 8'd1 : 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
